norm_lzc_pipe: RTL and testbench
================================

Name: norm_lzc_pipe

Overview:
- Parametrised, pipelined mantissa normaliser for the IEEE adder datapath; successor to the fixed 24-bit combinational leading-zero counter.
- Counts leading zeros over a MANT_W-bit mantissa, shifts the mantissa left and adjusts the biased exponent, with denormal clamping and zero detection.
- Two-stage pipeline with a valid/ready handshake and full backpressure; sits between the post-add mantissa register and the rounding stage.

Parameters:
- MANT_W, 24, mantissa width including hidden bit (single precision 24, double 53).
- EXP_W, 8, biased exponent width.
- CNT_W, $clog2(MANT_W+1), leading-zero count width; must represent MANT_W.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_mant  in  MANT_W  unnormalised mantissa; MSB is the hidden-bit position
- in_exp  in  EXP_W  biased exponent associated with in_mant
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the beat
- out_mant  out  MANT_W  normalised mantissa
- out_exp  out  EXP_W  adjusted biased exponent
- out_lz  out  CNT_W  raw leading-zero count of the input (MANT_W when the input is zero)
- out_zero  out  1  input mantissa was all zeros
- out_denorm  out  1  result clamped to the denormal range (out_exp = 0, mantissa not fully normalised)

Behaviour:
- Reset: the synchronous rst clears both stage valid bits. Reset values are out_valid=0, out_mant=0, out_exp=0, out_lz=0, out_zero=0, out_denorm=0. in_ready is 1 in the first cycle after reset.
- Reset mid-operation discards all in-flight beats. No output is produced for them.
- Handshake:
  - A transfer occurs when valid && ready.
  - in_ready = !s1_valid || s2_ready, where s2_ready = !out_valid || out_ready.
  - in_ready must not depend combinationally on in_valid.
  - out_valid, once high, stays high and all out_* stay stable until out_ready.
- Latency: exactly 2 cycles from input transfer to out_valid when there are no stalls. Throughput is 1 beat per cycle with out_ready held high.
- Stage 1 registers:
  - in_mant and in_exp.
  - lz = the number of zero bits above the highest set bit; lz = MANT_W if in_mant = 0.
  - zero = (in_mant == 0).
  - The leading-zero count is a priority search from MSB down to LSB, generalised over MANT_W.
- Stage 2 computes and registers:
  - zero: out_mant=0, out_exp=0, out_denorm=0, out_zero=1.
  - else if lz < in_exp: shift = lz, out_exp = in_exp - lz (≥1), out_denorm=0.
  - else (underflow, including in_exp=0): shift = (in_exp==0) ? 0 : in_exp-1, out_exp=0, out_denorm=1.
  - out_mant = in_mant << shift, with zero fill at the LSB. No bits are lost, because shift ≤ lz.
- Simultaneous events: when out_ready and in_valid are both asserted with the pipeline full, the pipeline advances by one beat. No bubble and no duplication.
- Width rules: all exponent arithmetic is unsigned at EXP_W bits; lz is zero-extended to EXP_W before comparison. The block requires MANT_W < 2**EXP_W.

Decomposition:
- Shared package fp_norm_pkg holds:
  - default width constants (SP_MANT_W=24, SP_EXP_W=8, DP_MANT_W=53, DP_EXP_W=11);
  - a clog2-based CNT_W helper function;
  - a stage-1 payload struct {mant, exp, lz, zero}.
- One sub-module is natural: lzc_param (parameter W), a purely combinational, parametrised leading-zero counter returning W for all-zero input. It is instantiated in stage 1.

Test Plan:
- MANT_W=24, in_mant=0x800000, in_exp=127 -> after 2 cycles: out_mant=0x800000, out_exp=127, out_lz=0, out_zero=0, out_denorm=0.
- in_mant=0x000100, in_exp=127 -> out_lz=15, out_mant=0x800000, out_exp=112.
- Underflow: in_mant=0x000001, in_exp=5 -> out_lz=23, shift 4, out_mant=0x000010, out_exp=0, out_denorm=1.
  - Same mantissa with in_exp=0 -> out_mant=0x000001, out_exp=0, out_denorm=1.
- Zero: in_mant=0, in_exp=200 -> out_zero=1, out_lz=24, out_mant=0, out_exp=0.
- Backpressure: 4 back-to-back beats with out_ready low for 3 cycles mid-stream.
  - in_ready drops only after both stages fill.
  - Outputs stay stable while stalled.
  - All 4 results emerge in order with no loss or duplication.
  - Assert rst during the stall: out_valid=0 on the next cycle and the in-flight beats are never emitted.

Source files
------------

// File: rtl/fp_norm_pkg.sv
// Shared widths, count-width helper and stage-1 payload for
// the mantissa normaliser.
package fp_norm_pkg;

  localparam int SP_MANT_W = 24;
  localparam int SP_EXP_W  = 8;
  localparam int DP_MANT_W = 53;
  localparam int DP_EXP_W  = 11;

  function automatic int cnt_w(input int mant_w);
    return $clog2(mant_w + 1);
  endfunction

  localparam int SP_CNT_W = cnt_w(SP_MANT_W);

  typedef struct packed {
    logic [SP_MANT_W-1:0] mant;
    logic [SP_EXP_W-1:0]  exp;
    logic [SP_CNT_W-1:0]  lz;
    logic                 zero;
  } s1_pay_t;

endpackage

// File: rtl/lzc_param.sv
// Combinational leading-zero counter; returns W for an
// all-zero input.
module lzc_param #(
  parameter int W  = 24,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  i_vec,
  output logic [CW-1:0] o_cnt
);

  logic w_found;

  always_comb begin
    o_cnt   = CW'(W);
    w_found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!w_found && i_vec[i]) begin
        o_cnt   = CW'(W - 1 - i);
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/norm_lzc_pipe.sv
// Two-stage mantissa normaliser: LZC in stage 1, shift and
// exponent adjust with denormal clamp in stage 2.
module norm_lzc_pipe
  import fp_norm_pkg::*;
#(
  parameter int MANT_W = SP_MANT_W,
  parameter int EXP_W  = SP_EXP_W,
  parameter int CNT_W  = cnt_w(MANT_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic [CNT_W-1:0]  out_lz,
  output logic              out_zero,
  output logic              out_denorm
);

  typedef struct packed {
    logic [MANT_W-1:0] mant;
    logic [EXP_W-1:0]  exp;
    logic [CNT_W-1:0]  lz;
    logic              zero;
  } s1_t;

  logic              r_s1_valid;
  s1_t               r_s1;
  logic              r_out_valid;
  logic [MANT_W-1:0] r_out_mant;
  logic [EXP_W-1:0]  r_out_exp;
  logic [CNT_W-1:0]  r_out_lz;
  logic              r_out_zero;
  logic              r_out_denorm;

  logic              w_s2_ready;
  logic [CNT_W-1:0]  w_lz;
  logic [EXP_W-1:0]  w_lz_e;
  logic [EXP_W-1:0]  w_shift;
  logic [EXP_W-1:0]  w_exp;
  logic              w_den;
  logic [MANT_W-1:0] w_mant;

  assign w_s2_ready = !r_out_valid || out_ready;
  assign in_ready   = !r_s1_valid || w_s2_ready;

  lzc_param #(.W(MANT_W), .CW(CNT_W)) u_lzc (
    .i_vec(in_mant),
    .o_cnt(w_lz)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1.mant <= in_mant;
        r_s1.exp  <= in_exp;
        r_s1.lz   <= w_lz;
        r_s1.zero <= (in_mant == '0);
      end
    end
  end

  // Underflow keeps the exponent at 1 before clamping to 0,
  // so the shift never exceeds the leading-zero count.
  assign w_lz_e = EXP_W'(r_s1.lz);

  always_comb begin
    w_shift = '0;
    w_exp   = '0;
    w_den   = 1'b0;
    if (r_s1.zero) begin
      w_shift = '0;
    end else if (w_lz_e < r_s1.exp) begin
      w_shift = w_lz_e;
      w_exp   = r_s1.exp - w_lz_e;
    end else begin
      w_shift = (r_s1.exp == '0) ? '0 : r_s1.exp - 1'b1;
      w_den   = 1'b1;
    end
  end

  assign w_mant = r_s1.zero ? '0 : (r_s1.mant << w_shift);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_mant   <= '0;
      r_out_exp    <= '0;
      r_out_lz     <= '0;
      r_out_zero   <= 1'b0;
      r_out_denorm <= 1'b0;
    end else if (w_s2_ready) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_mant   <= w_mant;
        r_out_exp    <= w_exp;
        r_out_lz     <= r_s1.lz;
        r_out_zero   <= r_s1.zero;
        r_out_denorm <= w_den;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_mant   = r_out_mant;
  assign out_exp    = r_out_exp;
  assign out_lz     = r_out_lz;
  assign out_zero   = r_out_zero;
  assign out_denorm = r_out_denorm;

endmodule

// File: tb/tb_norm_lzc_pipe.sv
// Directed bench for norm_lzc_pipe: vectors, throughput,
// backpressure and reset during a stall.
module tb_norm_lzc_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_mant;
  logic [7:0]  in_exp;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_mant;
  logic [7:0]  out_exp;
  logic [4:0]  out_lz;
  logic        out_zero;
  logic        out_denorm;

  int n_chk;
  int n_fail;

  typedef struct packed {
    logic [23:0] mant;
    logic [7:0]  exp;
    logic [23:0] e_mant;
    logic [7:0]  e_exp;
    logic [4:0]  e_lz;
    logic        e_zero;
    logic        e_den;
  } vec_t;

  vec_t vt[8];

  norm_lzc_pipe #(.MANT_W(24), .EXP_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_mant(in_mant),
    .in_exp(in_exp),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_mant(out_mant),
    .out_exp(out_exp),
    .out_lz(out_lz),
    .out_zero(out_zero),
    .out_denorm(out_denorm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic init_vecs();
    vt[0] = '{24'h800000, 8'd127, 24'h800000, 8'd127, 5'd0,  1'b0, 1'b0};
    vt[1] = '{24'h000100, 8'd127, 24'h800000, 8'd112, 5'd15, 1'b0, 1'b0};
    vt[2] = '{24'h000001, 8'd5,   24'h000010, 8'd0,   5'd23, 1'b0, 1'b1};
    vt[3] = '{24'h000001, 8'd0,   24'h000001, 8'd0,   5'd23, 1'b0, 1'b1};
    vt[4] = '{24'h000000, 8'd200, 24'h000000, 8'd0,   5'd24, 1'b1, 1'b0};
    vt[5] = '{24'h400000, 8'd1,   24'h400000, 8'd0,   5'd1,  1'b0, 1'b1};
    vt[6] = '{24'h400000, 8'd2,   24'h800000, 8'd1,   5'd1,  1'b0, 1'b0};
    vt[7] = '{24'h000003, 8'd255, 24'hC00000, 8'd233, 5'd22, 1'b0, 1'b0};
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_mant = '0; in_exp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    n_chk++;
    if ({out_mant, out_exp, out_lz, out_zero, out_denorm} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h/%h/%0d/%b/%b want all 0",
               out_mant, out_exp, out_lz, out_zero, out_denorm);
    end
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_vectors();
    out_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      in_valid = 1'b1; in_mant = vt[v].mant; in_exp = vt[v].exp;
      @(negedge clk);
      in_valid = 1'b0;
      n_chk++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL vec%0d_early: got %b want 0", v, out_valid);
      end
      @(negedge clk);
      n_chk++;
      if (out_valid !== 1'b1) begin
        n_fail++; $display("FAIL vec%0d_valid: got %b want 1", v, out_valid);
      end
      n_chk++;
      if (out_mant !== vt[v].e_mant) begin
        n_fail++;
        $display("FAIL vec%0d_mant: got %h want %h", v, out_mant, vt[v].e_mant);
      end
      n_chk++;
      if (out_exp !== vt[v].e_exp) begin
        n_fail++;
        $display("FAIL vec%0d_exp: got %0d want %0d", v, out_exp, vt[v].e_exp);
      end
      n_chk++;
      if (out_lz !== vt[v].e_lz) begin
        n_fail++;
        $display("FAIL vec%0d_lz: got %0d want %0d", v, out_lz, vt[v].e_lz);
      end
      n_chk++;
      if (out_zero !== vt[v].e_zero) begin
        n_fail++;
        $display("FAIL vec%0d_zero: got %b want %b", v, out_zero, vt[v].e_zero);
      end
      n_chk++;
      if (out_denorm !== vt[v].e_den) begin
        n_fail++;
        $display("FAIL vec%0d_denorm: got %b want %b", v, out_denorm, vt[v].e_den);
      end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        n_chk++;
        if (out_valid !== 1'b1) begin
          n_fail++; $display("FAIL b2b%0d_valid: got %b want 1", k, out_valid);
        end
        n_chk++;
        if (out_mant !== vt[k-2].e_mant || out_exp !== vt[k-2].e_exp
            || out_lz !== vt[k-2].e_lz) begin
          n_fail++;
          $display("FAIL b2b%0d_data: got %h/%0d/%0d want %h/%0d/%0d", k,
                   out_mant, out_exp, out_lz,
                   vt[k-2].e_mant, vt[k-2].e_exp, vt[k-2].e_lz);
        end
      end
      in_valid = (k < 4);
      if (k < 4) begin
        in_mant = vt[k].mant; in_exp = vt[k].exp;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int          tx;
    int          rx;
    int          idx[4];
    logic        held;
    logic        go;
    logic        exp_rdy;
    logic [23:0] s_mant;
    logic [7:0]  s_exp;
    logic [4:0]  s_lz;
    idx = '{1, 2, 5, 6};
    tx = 0; rx = 0; held = 1'b0;
    s_mant = '0; s_exp = '0; s_lz = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      out_ready = !(c >= 2 && c <= 4);
      in_valid  = (tx < 4);
      if (tx < 4) begin
        in_mant = vt[idx[tx]].mant; in_exp = vt[idx[tx]].exp;
      end
      #1;
      if (c <= 8) begin
        exp_rdy = !(c >= 2 && c <= 4);
        n_chk++;
        if (in_ready !== exp_rdy) begin
          n_fail++;
          $display("FAIL bp_in_ready_c%0d: got %b want %b", c, in_ready, exp_rdy);
        end
      end
      if (held) begin
        n_chk++;
        if (out_valid !== 1'b1 || out_mant !== s_mant
            || out_exp !== s_exp || out_lz !== s_lz) begin
          n_fail++;
          $display("FAIL bp_stable_c%0d: got %b/%h/%0d/%0d want 1/%h/%0d/%0d",
                   c, out_valid, out_mant, out_exp, out_lz, s_mant, s_exp, s_lz);
        end
      end
      if (out_valid && out_ready) begin
        n_chk++;
        if (rx >= 4) begin
          n_fail++; $display("FAIL bp_extra: got beat %0d want only 4", rx);
        end else if (out_mant !== vt[idx[rx]].e_mant
                     || out_exp !== vt[idx[rx]].e_exp
                     || out_lz !== vt[idx[rx]].e_lz) begin
          n_fail++;
          $display("FAIL bp_beat%0d: got %h/%0d/%0d want %h/%0d/%0d", rx,
                   out_mant, out_exp, out_lz, vt[idx[rx]].e_mant,
                   vt[idx[rx]].e_exp, vt[idx[rx]].e_lz);
        end
        rx++;
      end
      held = out_valid && !out_ready;
      s_mant = out_mant; s_exp = out_exp; s_lz = out_lz;
      go = in_valid && in_ready;
      @(posedge clk);
      if (go) tx++;
    end
    in_valid = 1'b0;
    n_chk++;
    if (rx !== 4 || tx !== 4) begin
      n_fail++; $display("FAIL bp_count: got rx=%0d tx=%0d want 4/4", rx, tx);
    end
  endtask

  task automatic test_reset_stall();
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_mant = vt[0].mant; in_exp = vt[0].exp;
    @(negedge clk);
    in_mant = vt[1].mant; in_exp = vt[1].exp;
    @(negedge clk);
    in_valid = 1'b0;
    n_chk++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rs_full: got valid=%b rdy=%b want 1/0", out_valid, in_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    n_chk++;
    if (out_valid !== 1'b0 || out_mant !== 24'h0) begin
      n_fail++;
      $display("FAIL rs_flush: got valid=%b mant=%h want 0/0", out_valid, out_mant);
    end
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rs_in_ready: got %b want 1", in_ready);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_chk++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL rs_ghost%0d: got %b want 0", k, out_valid);
      end
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    init_vecs();
    test_reset();
    test_vectors();
    test_back_to_back();
    test_backpressure();
    test_reset_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
